trace_capture: RTL and testbench
================================

Name: trace_capture

Overview:
- Synthesizable commit-trace recorder that replaces the per-cycle printing of the single-cycle mips core's testbench.
- Samples each committed instruction (PC, instruction word, GPR write port) into a circular buffer, with a cycle timestamp.
- Mode-selectable: free-running, fill-and-stop, or PC-triggered with a post-trigger window.
- Sits beside `mips`, fed from the pc/inst/gpr-write nets and halt_sig; drained through a valid/ready read port.

Parameters:
- DEPTH, 16, buffer entries; power of two, at least 4; AW = log2(DEPTH).
- PC_W, 32, PC and instruction width.
- DATA_W, 32, GPR write-data width.
- TS_W, 16, cycle-timestamp width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- mode  in  2  0 = circular, 1 = fill-stop, 2 = trigger, 3 = reserved (behaves as 0); sampled at arm.
- arm  in  1  single-cycle pulse; clears the buffer and starts capture.
- trig_pc  in  PC_W  trigger PC; sampled at arm.
- post_count  in  AW  entries captured after the trigger entry; sampled at arm.
- commit_valid  in  1  an instruction commits this cycle.
- commit_pc  in  PC_W  PC of the committing instruction.
- commit_inst  in  PC_W  instruction word.
- commit_we  in  1  GPR write enable.
- commit_waddr  in  5  GPR write address.
- commit_wdata  in  DATA_W  GPR write data.
- halt_sig  in  1  core halt.
- rd_ready  in  1  consumer accepts rd_data.
- rd_valid  out  1  rd_data holds the oldest unread entry.
- rd_data  out  TS_W+2*PC_W+6+DATA_W  {ts, pc, inst, we, waddr, wdata}.
- count  out  AW+1  entries held.
- overflow  out  1  sticky; at least one entry was overwritten.
- triggered  out  1  sticky; trigger PC matched.
- done  out  1  capture finished (state DONE).

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; wr_ptr=rd_ptr=0; count=0; ts=0.
  - overflow=triggered=0; rd_valid=0; rd_data=0.
  - Memory contents are don't-care.
- ts counter: increments on every clk edge outside reset and wraps modulo 2^TS_W. Each entry stores ts as seen in its capture cycle.
- States: IDLE, CAPTURE, POST, DONE.
- arm in any state, highest priority:
  - Pointers, count, overflow, triggered and the post counter clear.
  - mode, trig_pc and post_count are latched; state goes to CAPTURE.
  - A commit in the arm cycle is NOT captured.
- A capture happens in CAPTURE or POST when commit_valid==1:
  - Write the entry at wr_ptr; wr_ptr++ (wraps at DEPTH).
  - If count<DEPTH, count++.
  - Otherwise the write overwrites the oldest entry: rd_ptr++ and overflow<=1.
- Mode 0 (circular): stays in CAPTURE indefinitely; keeps the last DEPTH commits.
- Mode 1 (fill-stop):
  - The capture that makes count==DEPTH moves the block to DONE.
  - Overwrite never occurs, so overflow stays 0.
- Mode 2 (trigger):
  - CAPTURE runs circularly.
  - A captured commit with commit_pc==trig_pc sets triggered=1. That entry is stored.
  - If post_count==0, go to DONE; otherwise go to POST with remaining=post_count.
  - Each POST capture decrements remaining; reaching 0 moves to DONE.
  - The trigger entry is always present in the buffer.
- halt_sig==1 in CAPTURE or POST:
  - That cycle's commit, if valid, is captured first.
  - Then the block goes to DONE.
  - If the halt commit also matches trig_pc, triggered=1.
- IDLE and DONE ignore commits.
- Readout, legal in any state:
  - rd_valid = (count!=0) and rd_data = mem[rd_ptr], both combinational from registered state.
  - On rd_valid && rd_ready: rd_ptr++ and count--.
  - A pop and a capture in the same cycle: count is unchanged and both pointers advance. Overflow is not set unless count==DEPTH before the pop.
- done = (state==DONE). It stays 1 until arm or reset.
- Reset mid-capture: everything clears immediately; no partial entry remains.
- Latency: an entry captured at edge N is visible on rd_data after edge N, provided it is the oldest entry.

Decomposition:
- Shared package/header:
  - mode encodings and state encodings;
  - entry field offsets and the entry-width macro;
  - reuse the existing opcode macros for any bench-side disassembly.
- One sub-module, trace_ram: DEPTH x entry-width, 1 write port, 1 asynchronous read port, no reset.
- The FSM, pointers and counters stay in trace_capture.

Test Plan:
- Mode 1, DEPTH=16: arm, then 20 consecutive commits with pc=0x3000+4k → done after the 16th capture; count=16; overflow=0; the read drains pcs 0x3000..0x303C in order with ts strictly increasing by 1.
- Mode 0: 20 commits → count=16, overflow=1; first read pc=0x3010, last read pc=0x304C.
- Mode 2, trig_pc=0x3020, post_count=3: 12 commits → triggered=1; done after pc 0x302C; last 4 reads are 0x3020, 0x3024, 0x3028, 0x302C; commits after DONE are ignored.
- halt_sig together with a valid commit pc=0x3008 (we=1, waddr=8, wdata=0x1234) in CAPTURE → that entry is stored, then done=1; rd_data fields decode to exactly those values.
- Simultaneous pop and capture at count=16 in mode 0 → count stays 16 and overflow stays 0. Separately, reset pulled low mid-POST → the next cycle shows count=0, done=0, rd_valid=0, triggered=0.

Source files
------------

// File: rtl/trace_capture_pkg.sv
// Shared encodings and entry layout for the commit-trace recorder.
// Entry layout, MSB to LSB: {ts, pc, inst, we, waddr, wdata}.
`ifndef TRACE_ENTRY_W
`define TRACE_ENTRY_W(ts_w, pc_w, data_w) ((ts_w) + 2*(pc_w) + 6 + (data_w))
`endif

package trace_capture_pkg;

  typedef enum logic [1:0] {
    MODE_CIRC = 2'd0,
    MODE_FILL = 2'd1,
    MODE_TRIG = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int GPR_AW = 5;

  function automatic int entry_w(input int ts_w, input int pc_w, input int data_w);
    return `TRACE_ENTRY_W(ts_w, pc_w, data_w);
  endfunction

  // Field LSB offsets within an entry
  function automatic int waddr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int we_bit(input int data_w);
    return data_w + GPR_AW;
  endfunction

  function automatic int inst_lsb(input int data_w);
    return data_w + GPR_AW + 1;
  endfunction

  function automatic int pc_lsb(input int pc_w, input int data_w);
    return data_w + GPR_AW + 1 + pc_w;
  endfunction

  function automatic int ts_lsb(input int pc_w, input int data_w);
    return data_w + GPR_AW + 1 + 2*pc_w;
  endfunction

endpackage

// File: rtl/trace_capture_ram.sv
// Trace storage: one write port, one asynchronous read port, no reset.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 118,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture.sv
// Commit-trace recorder: captures committed instructions into a circular
// buffer in circular, fill-and-stop or PC-triggered mode; drained by valid/ready.
module trace_capture
  import trace_capture_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int TS_W   = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int EW    = entry_w(TS_W, PC_W, DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              arm,
  input  logic [PC_W-1:0]   trig_pc,
  input  logic [AW-1:0]     post_count,
  input  logic              commit_valid,
  input  logic [PC_W-1:0]   commit_pc,
  input  logic [PC_W-1:0]   commit_inst,
  input  logic              commit_we,
  input  logic [4:0]        commit_waddr,
  input  logic [DATA_W-1:0] commit_wdata,
  input  logic              halt_sig,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [EW-1:0]     rd_data,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              triggered,
  output logic              done
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_e            state_reg, state_next;
  mode_e             mode_reg, mode_next;
  logic [PC_W-1:0]   trig_pc_reg, trig_pc_next;
  logic [AW-1:0]     post_len_reg, post_len_next;
  logic [AW-1:0]     remaining_reg, remaining_next;
  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [AW:0]       count_reg, count_next;
  logic [TS_W-1:0]   ts_reg;
  logic              overflow_reg, overflow_next;
  logic              triggered_reg, triggered_next;

  logic              capture;
  logic              pop;
  logic              hit;
  logic [EW-1:0]     wr_entry;
  logic [EW-1:0]     ram_rdata;

  assign rd_valid = (count_reg != '0);
  assign pop      = rd_valid && rd_ready;
  assign wr_entry = {ts_reg, commit_pc, commit_inst, commit_we, commit_waddr, commit_wdata};

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    trig_pc_next   = trig_pc_reg;
    post_len_next  = post_len_reg;
    remaining_next = remaining_reg;
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    triggered_next = triggered_reg;
    capture        = 1'b0;
    hit            = 1'b0;

    if (arm) begin
      mode_next      = mode_e'(mode);
      trig_pc_next   = trig_pc;
      post_len_next  = post_count;
      remaining_next = '0;
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      count_next     = '0;
      overflow_next  = 1'b0;
      triggered_next = 1'b0;
      state_next     = ST_CAPTURE;
    end else begin
      capture = commit_valid && (state_reg == ST_CAPTURE || state_reg == ST_POST);
      hit     = capture && (state_reg == ST_CAPTURE) && (mode_reg == MODE_TRIG)
                && (commit_pc == trig_pc_reg);

      if (capture) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_next = rd_ptr_reg + AW'(1);

      // A concurrent pop frees the slot, so a full buffer only overwrites without one
      if (capture && !pop) begin
        if (count_reg == FULL) begin
          rd_ptr_next   = rd_ptr_reg + AW'(1);
          overflow_next = 1'b1;
        end else begin
          count_next = count_reg + (AW+1)'(1);
        end
      end else if (pop && !capture) begin
        count_next = count_reg - (AW+1)'(1);
      end

      case (state_reg)
        ST_CAPTURE: begin
          if (capture && mode_reg == MODE_FILL && count_next == FULL)
            state_next = ST_DONE;
          if (hit) begin
            triggered_next = 1'b1;
            if (post_len_reg == '0) begin
              state_next = ST_DONE;
            end else begin
              state_next     = ST_POST;
              remaining_next = post_len_reg;
            end
          end
        end
        ST_POST: begin
          if (capture) begin
            remaining_next = remaining_reg - AW'(1);
            if (remaining_reg == AW'(1)) state_next = ST_DONE;
          end
        end
        default: ;
      endcase

      if (halt_sig && (state_reg == ST_CAPTURE || state_reg == ST_POST))
        state_next = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      mode_reg      <= MODE_CIRC;
      trig_pc_reg   <= '0;
      post_len_reg  <= '0;
      remaining_reg <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      ts_reg        <= '0;
      overflow_reg  <= 1'b0;
      triggered_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      trig_pc_reg   <= trig_pc_next;
      post_len_reg  <= post_len_next;
      remaining_reg <= remaining_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      ts_reg        <= ts_reg + TS_W'(1);
      overflow_reg  <= overflow_next;
      triggered_reg <= triggered_next;
    end
  end

  trace_ram #(
    .DEPTH(DEPTH),
    .WIDTH(EW)
  ) u_ram (
    .clk   (clk),
    .we    (capture && reset),
    .waddr (wr_ptr_reg),
    .wdata (wr_entry),
    .raddr (rd_ptr_reg),
    .rdata (ram_rdata)
  );

  // Memory is never reset, so an empty buffer presents zeros
  assign rd_data   = rd_valid ? ram_rdata : '0;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign triggered = triggered_reg;
  assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: fill-stop, circular, trigger, halt,
// concurrent pop/capture and mid-capture reset.
module tb_trace_capture;

  localparam int EW = 118;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic          arm;
  logic [31:0]   trig_pc;
  logic [3:0]    post_count;
  logic          commit_valid;
  logic [31:0]   commit_pc;
  logic [31:0]   commit_inst;
  logic          commit_we;
  logic [4:0]    commit_waddr;
  logic [31:0]   commit_wdata;
  logic          halt_sig;
  logic          rd_ready;
  logic          rd_valid;
  logic [EW-1:0] rd_data;
  logic [4:0]    count;
  logic          overflow;
  logic          triggered;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] tb_ts = '0;
  logic [15:0] ts_log [64];

  always #5 clk = ~clk;

  // Reference cycle counter, same reset and wrap behaviour as the recorder
  always @(posedge clk) begin
    if (!reset) tb_ts <= '0;
    else        tb_ts <= tb_ts + 16'd1;
  end

  trace_capture dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .arm          (arm),
    .trig_pc      (trig_pc),
    .post_count   (post_count),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_inst  (commit_inst),
    .commit_we    (commit_we),
    .commit_waddr (commit_waddr),
    .commit_wdata (commit_wdata),
    .halt_sig     (halt_sig),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .count        (count),
    .overflow     (overflow),
    .triggered    (triggered),
    .done         (done)
  );

  wire [15:0] f_ts    = rd_data[117:102];
  wire [31:0] f_pc    = rd_data[101:70];
  wire [31:0] f_inst  = rd_data[69:38];
  wire        f_we    = rd_data[37];
  wire [4:0]  f_waddr = rd_data[36:32];
  wire [31:0] f_wdata = rd_data[31:0];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [31:0] tp, input logic [3:0] pc_n);
    arm = 1'b1; mode = m; trig_pc = tp; post_count = pc_n;
    tick();
    arm = 1'b0;
  endtask

  task automatic commit_full(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                             input logic [4:0] wa, input logic [31:0] wd, input logic h);
    commit_valid = 1'b1; commit_pc = pc; commit_inst = inst;
    commit_we = we; commit_waddr = wa; commit_wdata = wd; halt_sig = h;
    ts_log[(pc - 32'h3000) >> 2] = tb_ts;
    tick();
    commit_valid = 1'b0; halt_sig = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc);
    commit_full(pc, {16'h2400, pc[15:0]}, 1'b1, pc[6:2], ~pc, 1'b0);
  endtask

  task automatic pop();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; mode = 2'd0; arm = 1'b0; trig_pc = '0; post_count = '0;
    commit_valid = 1'b0; commit_pc = '0; commit_inst = '0; commit_we = 1'b0;
    commit_waddr = '0; commit_wdata = '0; halt_sig = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_valid", 128'(rd_valid), 128'd0);
    chk("rst_data", 128'(rd_data), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_ovf", 128'(overflow), 128'd0);
    chk("rst_trig", 128'(triggered), 128'd0);
    reset = 1'b1;
    tick();
    commit(32'h2000);
    chk("idle_ignores", 128'(count), 128'd0);

    // Fill-stop: done after the 16th capture, later commits dropped
    do_arm(2'd1, '0, 4'd0);
    for (int k = 0; k < 20; k++) begin
      commit(32'h3000 + 32'(4*k));
      chk($sformatf("fill_done_k%0d", k), 128'(done), 128'(k >= 15));
      chk($sformatf("fill_cnt_k%0d", k), 128'(count), 128'(k >= 15 ? 16 : k + 1));
    end
    chk("fill_ovf", 128'(overflow), 128'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fill_pc_%0d", i), 128'(f_pc), 128'(32'h3000 + 32'(4*i)));
      chk($sformatf("fill_ts_%0d", i), 128'(f_ts), 128'(ts_log[0] + 16'(i)));
      pop();
    end
    chk("fill_empty", 128'(rd_valid), 128'd0);

    // Circular: keeps the last 16 of 20
    do_arm(2'd0, '0, 4'd0);
    for (int k = 0; k < 20; k++) commit(32'h3000 + 32'(4*k));
    chk("circ_cnt", 128'(count), 128'd16);
    chk("circ_ovf", 128'(overflow), 128'd1);
    chk("circ_done", 128'(done), 128'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("circ_pc_%0d", i), 128'(f_pc), 128'(32'h3010 + 32'(4*i)));
      pop();
    end

    // Trigger at 0x3020 with three post entries
    do_arm(2'd2, 32'h3020, 4'd3);
    for (int k = 0; k < 12; k++) begin
      commit(32'h3000 + 32'(4*k));
      chk($sformatf("trg_done_k%0d", k), 128'(done), 128'(k >= 11));
      chk($sformatf("trg_hit_k%0d", k), 128'(triggered), 128'(k >= 8));
    end
    commit(32'h3030);
    commit(32'h3034);
    chk("trg_after_done", 128'(count), 128'd12);
    for (int i = 0; i < 8; i++) pop();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("trg_pc_%0d", i), 128'(f_pc), 128'(32'h3020 + 32'(4*i)));
      pop();
    end

    // Halt with a valid commit: entry kept, then done
    do_arm(2'd0, '0, 4'd0);
    commit(32'h3000);
    commit(32'h3004);
    commit_full(32'h3008, 32'h8C08_0000, 1'b1, 5'd8, 32'h1234, 1'b1);
    chk("halt_done", 128'(done), 128'd1);
    chk("halt_cnt", 128'(count), 128'd3);
    pop(); pop();
    chk("halt_entry", 128'(rd_data),
        128'({ts_log[2], 32'h3008, 32'h8C08_0000, 1'b1, 5'd8, 32'h1234}));

    // Concurrent pop and capture while full: no overwrite
    do_arm(2'd0, '0, 4'd0);
    for (int k = 0; k < 16; k++) commit(32'h3000 + 32'(4*k));
    chk("pc_full_cnt", 128'(count), 128'd16);
    rd_ready = 1'b1;
    commit(32'h3040);
    rd_ready = 1'b0;
    chk("pc_cnt", 128'(count), 128'd16);
    chk("pc_ovf", 128'(overflow), 128'd0);
    chk("pc_head", 128'(f_pc), 128'(32'h3004));

    // Reset during POST clears everything
    do_arm(2'd2, 32'h3000, 4'd5);
    commit(32'h3000);
    commit(32'h3004);
    chk("post_trig", 128'(triggered), 128'd1);
    chk("post_notdone", 128'(done), 128'd0);
    reset = 1'b0;
    tick();
    chk("mrst_cnt", 128'(count), 128'd0);
    chk("mrst_done", 128'(done), 128'd0);
    chk("mrst_valid", 128'(rd_valid), 128'd0);
    chk("mrst_trig", 128'(triggered), 128'd0);
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
